seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Consumer of the stopwatch counter's BCD time reading; drives the BASYS3 4-digit multiplexed seven-segment display.
- Time-multiplexes four BCD digits onto shared active-low segment lines at a fixed per-digit refresh rate.
- Snapshots the input once per scan frame so a digit never tears mid-frame.
- Sits between Counter (lower 8 bits: tens/ones of seconds) and the board pins.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- DIGIT_HZ, 1000, digit-advance rate in Hz. TICK_DIV = CLK_FREQ/DIGIT_HZ, must be >= 2; frame rate = DIGIT_HZ/4.

Ports:
- clk  in  1  system clock, rising edge.
- init_regs_n  in  1  asynchronous, active-low reset.
- disp_value  in  16  four BCD digits; [3:0] digit0 (rightmost) .. [15:12] digit3.
- dp_mask  in  4  decimal point request per digit, 1 = lit; bit i maps to digit i.
- display_on  in  1  0 = all anodes off; scanning continues.
- an  out  4  anode enables, active-low; an[0] = rightmost digit.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point cathode, active-low.

Behaviour:
- Reset (async assert, sync release): prescaler=0, idx=3, snapshot=16'h0000, dp snapshot=0, an=4'b1111, seg=7'b1111111, dp=1.
- Prescaler counts 0..TICK_DIV-1; tick = (prescaler==TICK_DIV-1); on tick prescaler->0.
- On tick: idx -> (idx+1) mod 4. On the 3->0 wrap, snapshot<=disp_value and dp snapshot<=dp_mask, both sampled on that edge.
- Outputs are registered on the tick edge from the new idx and the new snapshot, giving zero-cycle skew between an/seg/dp. They hold for exactly TICK_DIV cycles.
- First tick after reset release occurs TICK_DIV cycles later and selects digit 0 with a fresh snapshot. Until then outputs keep their reset values.
- an: only bit idx is low, provided display_on=1 on the tick edge. Otherwise an=4'b1111. display_on is sampled only on tick edges.
- seg encoding, nibble -> pattern (hex of {g..a}):
  - 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78, 8->00, 9->10.
  - Non-BCD nibbles A-F -> 3F (dash, segment g only).
- dp = ~dp snapshot[idx].
- Input changes mid-frame have no effect until the next 3->0 wrap.
- Reset asserted mid-frame returns all state to reset values immediately.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined: digit k (k=3..1) is blanked (an bit stays 1, seg=7F) when snapshot digits k..3 are all 0. Digit 0 is never blanked. dp on a blanked digit is forced to 1 (off).
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_0..SEG_9, SEG_DASH, SEG_BLANK, ANODES_OFF constants.
  - digit-index typedef (2-bit).
  - function for TICK_DIV computation.
- One combinational sub-module, bcd_to_seg (4-bit nibble -> 7-bit active-low pattern), instantiated once on the muxed digit.
- Prescaler, index, snapshot and output registers live in the top.

Test Plan:
- Reset and timing: CLK_FREQ=1000, DIGIT_HZ=100 (TICK_DIV=10), disp_value=16'h0012, hold init_regs_n low then release.
  - During reset: an=1111, seg=7F, dp=1.
  - 10 cycles after release: an=1110, seg=24.
  - 10 cycles later: an=1101, seg=79.
  - Then an=1011 and an=0111 with seg=40 (feature off).
- Snapshot: change disp_value to 16'h0034 while idx=1 -> digits 2 and 3 still show old values. New value appears at the next digit-0 slot (seg=19).
- Non-BCD and decimal point: disp_value=16'h00A9, dp_mask=4'b0010 -> digit0 seg=10 dp=1; digit1 seg=3F dp=0.
- display_on=0 -> an=1111 every slot while the idx sequence still advances. Re-enable -> the next tick lights the correct next digit.
- Async reset mid-frame: assert init_regs_n between clock edges -> outputs return to reset values before the next edge. After release, the first tick again lands on digit 0.
- With LEADING_ZERO_BLANK_EN:
  - disp_value=16'h0005 -> digits 3..1 keep an bit=1. Digit 0 shows seg=12.
  - disp_value=16'h0000 -> only digit 0 is lit, seg=40.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment patterns, digit index type and prescaler helper for the display scanner
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODES_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Clock cycles spent on each digit before advancing to the next one.
    function automatic int tick_div(input int clk_freq, input int digit_hz);
        return clk_freq / digit_hz;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg.sv
// bcd_to_seg: BCD nibble to active-low {g..a} pattern; non-BCD codes show a dash
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Pure lookup; A-F fall through to the dash so bad counter data is visible.
    always_comb begin
        pattern = SEG_DASH;
        case (nibble)
            4'd0: pattern = SEG_0;
            4'd1: pattern = SEG_1;
            4'd2: pattern = SEG_2;
            4'd3: pattern = SEG_3;
            4'd4: pattern = SEG_4;
            4'd5: pattern = SEG_5;
            4'd6: pattern = SEG_6;
            4'd7: pattern = SEG_7;
            4'd8: pattern = SEG_8;
            4'd9: pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexes four BCD digits onto the shared active-low segment lines.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int DIGIT_HZ = 1000
) (
    input  logic        clk,
    input  logic        init_regs_n,
    input  logic [15:0] disp_value,
    input  logic [3:0]  dp_mask,
    input  logic        display_on,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int TICK_DIV = tick_div(CLK_FREQ, DIGIT_HZ);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] presc;
    digit_idx_t    idx;
    digit_idx_t    idx_nxt;
    logic [15:0]   snap;
    logic [15:0]   snap_nxt;
    logic [3:0]    dps;
    logic [3:0]    dps_nxt;
    logic [3:0]    nib;
    logic [6:0]    pat;
    logic          tick;
    logic          blank;

    assign tick = presc == PW'(TICK_DIV - 1);

    // Values the registers take on a tick: next digit, and a fresh snapshot only on the 3->0 wrap.
    always_comb begin
        idx_nxt  = idx + 2'd1;
        snap_nxt = (idx == 2'd3) ? disp_value : snap;
        dps_nxt  = (idx == 2'd3) ? dp_mask : dps;
        nib      = snap_nxt[{idx_nxt, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank    = (idx_nxt == 2'd3 && snap_nxt[15:12] == 4'h0) ||
                   (idx_nxt == 2'd2 && snap_nxt[15:8] == 8'h00) ||
                   (idx_nxt == 2'd1 && snap_nxt[15:4] == 12'h000);
`else
        blank    = 1'b0;
`endif
    end

    bcd_to_seg u_bcd_to_seg (
        .nibble  (nib),
        .pattern (pat)
    );

    // Free-running prescaler producing one tick every TICK_DIV cycles.
    always_ff @(posedge clk or negedge init_regs_n) begin
        if (!init_regs_n) presc <= '0;
        else              presc <= tick ? '0 : presc + 1'b1;
    end

    // Digit index, frame snapshot and outputs all move together on the tick so an/seg/dp never skew.
    always_ff @(posedge clk or negedge init_regs_n) begin
        if (!init_regs_n) begin
            idx  <= 2'd3;
            snap <= 16'h0000;
            dps  <= 4'h0;
            an   <= ANODES_OFF;
            seg  <= SEG_BLANK;
            dp   <= 1'b1;
        end else if (tick) begin
            idx  <= idx_nxt;
            snap <= snap_nxt;
            dps  <= dps_nxt;
            an   <= (display_on && !blank) ? ~(4'b0001 << idx_nxt) : ANODES_OFF;
            seg  <= blank ? SEG_BLANK : pat;
            dp   <= blank | ~dps_nxt[idx_nxt];
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of scan timing, snapshotting, encoding, display enable and reset
// Expectations adapt when LEADING_ZERO_BLANK_EN is defined.
module tb_seven_seg_scanner;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        init_regs_n;
    logic [15:0] disp_value;
    logic [3:0]  dp_mask;
    logic        display_on;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_asrt = 0;
    int n_fail = 0;

    seven_seg_scanner #(.CLK_FREQ(1000), .DIGIT_HZ(100)) dut (
        .clk         (clk),
        .init_regs_n (init_regs_n),
        .disp_value  (disp_value),
        .dp_mask     (dp_mask),
        .display_on  (display_on),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e, input logic dp_e);
        chk({tag, ".an"}, {3'b000, an}, {3'b000, an_e});
        chk({tag, ".seg"}, seg, seg_e);
        chk({tag, ".dp"}, {6'b0, dp}, {6'b0, dp_e});
    endtask

    initial begin
        init_regs_n = 1'b0;
        disp_value  = 16'h0012;
        dp_mask     = 4'b0000;
        display_on  = 1'b1;
        step(3);
        chk3("reset", 4'b1111, 7'h7F, 1'b1);
        @(negedge clk);
        init_regs_n = 1'b1;
        step(9);
        chk3("pre_first_tick", 4'b1111, 7'h7F, 1'b1);
        step(1);
        chk3("d0_first", 4'b1110, 7'h24, 1'b1);
        step(10);
        chk3("d1_first", 4'b1101, 7'h79, 1'b1);
        step(10);
        chk3("d2_first", LZB ? 4'b1111 : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b1);
        step(10);
        chk3("d3_first", LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1);
        step(10);
        chk3("d0_second", 4'b1110, 7'h24, 1'b1);
        step(10);
        chk3("d1_second", 4'b1101, 7'h79, 1'b1);
        disp_value = 16'h0034;
        step(10);
        chk3("d2_old_snap", LZB ? 4'b1111 : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b1);
        step(10);
        chk3("d3_old_snap", LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1);
        step(10);
        chk3("d0_new_snap", 4'b1110, 7'h19, 1'b1);
        step(10);
        chk3("d1_new_snap", 4'b1101, 7'h30, 1'b1);
        disp_value = 16'h00A9;
        dp_mask    = 4'b0010;
        step(20);
        step(10);
        chk3("d0_nine", 4'b1110, 7'h10, 1'b1);
        step(10);
        chk3("d1_dash_dp", 4'b1101, 7'h3F, 1'b0);
        display_on = 1'b0;
        step(10);
        chk3("off_d2", 4'b1111, LZB ? 7'h7F : 7'h40, 1'b1);
        step(10);
        chk3("off_d3", 4'b1111, LZB ? 7'h7F : 7'h40, 1'b1);
        step(10);
        chk3("off_d0", 4'b1111, 7'h10, 1'b1);
        display_on = 1'b1;
        step(10);
        chk3("reenable_d1", 4'b1101, 7'h3F, 1'b0);
        #3;
        init_regs_n = 1'b0;
        #1;
        chk3("async_reset", 4'b1111, 7'h7F, 1'b1);
        @(negedge clk);
        disp_value = 16'h0005;
        dp_mask    = 4'b0000;
        @(negedge clk);
        init_regs_n = 1'b1;
        step(9);
        chk3("rel_pre_tick", 4'b1111, 7'h7F, 1'b1);
        step(1);
        chk3("rel_d0", 4'b1110, 7'h12, 1'b1);
        step(10);
        chk3("lz5_d1", LZB ? 4'b1111 : 4'b1101, LZB ? 7'h7F : 7'h40, 1'b1);
        step(10);
        chk3("lz5_d2", LZB ? 4'b1111 : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b1);
        disp_value = 16'h0000;
        dp_mask    = 4'b0010;
        step(10);
        chk3("lz5_d3", LZB ? 4'b1111 : 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1);
        step(10);
        chk3("lz0_d0", 4'b1110, 7'h40, 1'b1);
        step(10);
        chk3("lz0_d1", LZB ? 4'b1111 : 4'b1101, LZB ? 7'h7F : 7'h40, LZB ? 1'b1 : 1'b0);
        step(10);
        chk3("lz0_d2", LZB ? 4'b1111 : 4'b1011, LZB ? 7'h7F : 7'h40, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
